xed_decoder_10: RTL and testbench
=================================

// Module: xed_decoder_10
// PURPOSE
//  Receive-side counterpart of the XED encoder. Takes one stored codeword: 8 chips x 16 B, 8 per-chip CRC-ATM bytes, two 64-bit simple-XOR
//  groups, two 64-bit weighted-XOR groups and their two CRCs. Locates failed chips by CRC mismatch, rebuilds up to two chips from the parities.
//  Returns corrected data, a status code and an error mask. Sits between the memory read path and the requester, behind a valid/ready handshake.
// PARAMETERS
//  CRC_INIT   8'hFF  CRC-ATM seed (poly 0x07, MSB-byte first, final invert)
//  GF_POLY    8'h1D  low byte of the GF(256) primitive poly 0x11D; chip k weight = alpha^k = 8'h01<<k
// PORTS
//  clk              in   1     clock
//  rst_n            in   1     async active-low reset
//  in_valid         in   1     codeword present
//  in_ready         out  1     decoder accepts codeword (IDLE only)
//  chip_data_in     in   1024  chip k at [128k+127:128k]; group0 = low 64 b, group1 = high 64 b
//  chip_crc_in      in   64    chip k CRC at [8k+7:8k]
//  xor_parity_in    in   128   {simple group1, simple group0}
//  wxor_parity_in   in   128   {weighted group1, weighted group0}
//  simple_crc_in    in   8     CRC of xor_parity_in
//  weighted_crc_in  in   8     CRC of wxor_parity_in
//  out_valid        out  1     result valid; held until out_ready
//  out_ready        in   1     consumer accepts result
//  chip_data_out    out  1024  corrected chip data (same packing)
//  err_mask         out  8     bit k = chip k CRC mismatched
//  parity_err       out  2     {weighted CRC bad, simple CRC bad}
//  dec_status       out  2     00 clean, 01 one chip fixed, 10 two chips fixed, 11 uncorrectable
// BEHAVIOUR
//  - Reset: in_ready=0 during reset, 1 the first cycle after it; all other outputs 0; FSM=IDLE. Reset mid-operation aborts and drops the codeword.
//  - IDLE: in_ready=1. On in_valid&&in_ready, register all inputs and go to CHECK. No other input is sampled until the FSM returns to IDLE.
//  - CHECK: one shared CRC unit, 10 cycles. Cycles 0-7 check chips 0-7, cycle 8 checks the simple-XOR block, cycle 9 the weighted-XOR block.
//    A 4-bit counter sets err_mask/parity_err bits. Counter wraps 9->0, then go to CORRECT.
//  - CORRECT (1 cycle), F = popcount(err_mask); S/W = simple/weighted parity XOR the sum of the good chips:
//    F=0 -> data passes through, status 00 (parity errors only raise parity_err).
//    F=1, simple CRC good -> chip k = S, status 01.
//    F=1, simple CRC bad, weighted CRC good -> chip k = alpha^-k * W, status 01.
//    F=2 (a<b), both parity CRCs good -> Da = (W ^ alpha^b*S) * inv(alpha^a^alpha^b), Db = S ^ Da, status 10.
//    Otherwise -> status 11; data is raw.
//    All GF math is bytewise per 64-bit group, applied to both groups.
//  - DONE: out_valid=1, outputs stable until out_valid&&out_ready. Then go to IDLE; in_ready rises the next cycle.
//  - Latency from accept to out_valid = 12 cycles (13 with recheck); throughput is 1 codeword per 13+ cycles.
//  - out_ready held high at DONE entry -> a single out_valid pulse. out_ready ignored outside DONE.
// CONFIGURATION
//  XED_DEC_RECHECK_EN defined -> RECHECK state after CORRECT (+1 cycle): each rebuilt chip's CRC recomputed against chip_crc_in.
//    Any mismatch forces status 11 and raw data out.
//  Undefined -> no RECHECK state, rebuilt data trusted.
// STRUCTURE
//  Package xed_pkg: NUM_CHIPS=8, CRC_INIT, GF_POLY, ALPHA_POW[0:7], ALPHA_INV[0:7], state enum {IDLE,CHECK,CORRECT,RECHECK,DONE},
//   status encodings, functions gf256_mul and gf256_inv (x^254).
//  Sub-module: xed_crc_step, a combinational 16-byte CRC-ATM shared across the CHECK cycles. GF multiply stays as package functions.
// TESTING
//  1 chip k = {16{8'h11*k}} plus golden encoder outputs -> status 00, err_mask 00, data equal, out_valid 12 cycles after accept.
//  2 same codeword with chip 3 byte0 flipped ^8'hA5 -> err_mask 08, status 01, chip 3 restored.
//  3 chips 1 and 6 overwritten with 128'hDEADBEEF_... -> err_mask 42, status 10, both restored via weighted parity.
//  4 chip 5 and simple_crc_in corrupted -> parity_err 01, status 01, chip 5 restored from weighted parity.
//  5 chips 0,2,7 corrupted -> err_mask 85, status 11, raw data out.
//  6 out_ready low 5 cycles in DONE -> outputs stable, in_ready 0. rst_n pulsed during CHECK -> outputs 0, no out_valid, fresh accept works.

Source files
------------

// File: rtl/xed_pkg.sv
// Shared constants, types and GF(256) helpers for the XED decoder.
// Optional build macro used by the decoder: XED_DEC_RECHECK_EN.
package xed_pkg;

    localparam int unsigned NUM_CHIPS  = 8;
    localparam int unsigned CHIP_BYTES = 16;
    localparam int unsigned CHIP_W     = CHIP_BYTES * 8;
    localparam int unsigned DATA_W     = NUM_CHIPS * CHIP_W;
    localparam int unsigned PAR_W      = 128;

    localparam logic [7:0] CRC_INIT = 8'hFF;
    localparam logic [7:0] CRC_POLY = 8'h07;
    localparam logic [7:0] GF_POLY  = 8'h1D;

    // alpha^k and alpha^-k for the chip weights (alpha = 2, poly 0x11D)
    localparam logic [7:0] ALPHA_POW [NUM_CHIPS] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80
    };
    localparam logic [7:0] ALPHA_INV [NUM_CHIPS] = '{
        8'h01, 8'h8E, 8'h47, 8'hAD, 8'hD8, 8'h6C, 8'h36, 8'h1B
    };

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StCorrect,
        StRecheck,
        StDone
    } dec_state_e;

    typedef enum logic [1:0] {
        StatClean  = 2'b00,
        StatOne    = 2'b01,
        StatTwo    = 2'b10,
        StatUncorr = 2'b11
    } dec_status_e;

    function automatic logic [7:0] gf256_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ GF_POLY) : (x << 1);
        end
        return p;
    endfunction

    // x^254 == x^-1; maps 0 to 0
    function automatic logic [7:0] gf256_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf256_mul(sq, sq);
            r  = gf256_mul(r, sq);
        end
        return r;
    endfunction

endpackage

// File: rtl/xed_decoder_10_if.sv
// Codeword-in / result-out handshake bundle for xed_decoder_10.
interface xed_decoder_10_if;
    import xed_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   chip_data_in;
    logic [63:0]         chip_crc_in;
    logic [PAR_W-1:0]    xor_parity_in;
    logic [PAR_W-1:0]    wxor_parity_in;
    logic [7:0]          simple_crc_in;
    logic [7:0]          weighted_crc_in;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   chip_data_out;
    logic [7:0]          err_mask;
    logic [1:0]          parity_err;
    logic [1:0]          dec_status;

    modport master (
        output in_valid, chip_data_in, chip_crc_in, xor_parity_in, wxor_parity_in,
               simple_crc_in, weighted_crc_in, out_ready,
        input  in_ready, out_valid, chip_data_out, err_mask, parity_err, dec_status
    );

    modport slave (
        input  in_valid, chip_data_in, chip_crc_in, xor_parity_in, wxor_parity_in,
               simple_crc_in, weighted_crc_in, out_ready,
        output in_ready, out_valid, chip_data_out, err_mask, parity_err, dec_status
    );

endinterface

// File: rtl/xed_crc_step.sv
// Combinational CRC-ATM over one 16-byte block, most significant byte first.
module xed_crc_step
    import xed_pkg::*;
(
    input  logic [CHIP_W-1:0] data_i,
    output logic [7:0]        crc_o
);

    logic [7:0] c;

    // Byte-serial CRC unrolled; final value inverted
    always_comb begin
        c = CRC_INIT;
        for (int i = CHIP_BYTES - 1; i >= 0; i--) begin
            c = c ^ data_i[8*i +: 8];
            for (int b = 0; b < 8; b++) begin
                c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
            end
        end
        crc_o = ~c;
    end

endmodule

// File: rtl/xed_decoder_10.sv
// XED receive-side decoder: CRC-locates failed chips, rebuilds up to two from the parities.
// Build option: define XED_DEC_RECHECK_EN to re-verify rebuilt chips against their stored CRC.
module xed_decoder_10
    import xed_pkg::*;
(
    input logic             clk,
    input logic             rst_n,
    xed_decoder_10_if.slave bus
);

    dec_state_e         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [7:0]         err_mask_q, err_mask_d;
    logic [1:0]         parity_err_q, parity_err_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic [1:0]         status_q, status_d;
    logic               in_ready_q;

    logic [DATA_W-1:0]  raw_q;
    logic [63:0]        crc_q;
    logic [PAR_W-1:0]   xp_q, wp_q;
    logic [7:0]         sc_q, wc_q;

    logic               accept;
    logic [CHIP_W-1:0]  crc_blk;
    logic [7:0]         crc_exp, crc_calc;
    logic               crc_bad;

    logic [PAR_W-1:0]   syn_s, syn_w;
    logic [2:0]         idx_a, idx_b;
    logic [3:0]         n_fail;
    logic [7:0]         denom_inv, da;
    logic [CHIP_W-1:0]  rb_w1, rb_da, rb_db;
    logic [DATA_W-1:0]  fix_data;
    logic [1:0]         fix_status;

    assign accept = (state_q == StIdle) && bus.in_valid && in_ready_q;

    // Capture the whole codeword on accept; held untouched until the next accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q <= '0;
            crc_q <= '0;
            xp_q  <= '0;
            wp_q  <= '0;
            sc_q  <= '0;
            wc_q  <= '0;
        end else if (accept) begin
            raw_q <= bus.chip_data_in;
            crc_q <= bus.chip_crc_in;
            xp_q  <= bus.xor_parity_in;
            wp_q  <= bus.wxor_parity_in;
            sc_q  <= bus.simple_crc_in;
            wc_q  <= bus.weighted_crc_in;
        end
    end

    // Shared CRC unit input select: chips 0-7, then simple block, then weighted block
    always_comb begin
        crc_blk = xp_q;
        crc_exp = sc_q;
        if (cnt_q < 4'd8) begin
            crc_blk = raw_q[{cnt_q[2:0], 7'd0} +: CHIP_W];
            crc_exp = crc_q[{cnt_q[2:0], 3'd0} +: 8];
        end else if (cnt_q == 4'd9) begin
            crc_blk = wp_q;
            crc_exp = wc_q;
        end
    end

    xed_crc_step u_crc (
        .data_i (crc_blk),
        .crc_o  (crc_calc)
    );

    assign crc_bad = (crc_calc != crc_exp);

    // Syndromes: parities with every good chip's (weighted) contribution removed
    always_comb begin
        syn_s = xp_q;
        syn_w = wp_q;
        for (int k = 0; k < NUM_CHIPS; k++) begin
            if (!err_mask_q[k]) begin
                for (int i = 0; i < CHIP_BYTES; i++) begin
                    syn_s[8*i +: 8] = syn_s[8*i +: 8] ^ raw_q[CHIP_W*k + 8*i +: 8];
                    syn_w[8*i +: 8] = syn_w[8*i +: 8]
                                    ^ gf256_mul(ALPHA_POW[k], raw_q[CHIP_W*k + 8*i +: 8]);
                end
            end
        end
    end

    // Failed-chip count plus lowest (a) and highest (b) failed index
    always_comb begin
        n_fail = 4'd0;
        idx_a  = 3'd0;
        idx_b  = 3'd0;
        for (int k = NUM_CHIPS - 1; k >= 0; k--) begin
            if (err_mask_q[k]) idx_a = 3'(k);
        end
        for (int k = 0; k < NUM_CHIPS; k++) begin
            if (err_mask_q[k]) begin
                idx_b  = 3'(k);
                n_fail = n_fail + 4'd1;
            end
        end
    end

    // Candidate rebuilds and the resulting corrected word / status
    always_comb begin
        rb_w1      = '0;
        rb_da      = '0;
        rb_db      = '0;
        da         = 8'h00;
        denom_inv  = gf256_inv(ALPHA_POW[idx_a] ^ ALPHA_POW[idx_b]);
        for (int i = 0; i < CHIP_BYTES; i++) begin
            rb_w1[8*i +: 8] = gf256_mul(ALPHA_INV[idx_a], syn_w[8*i +: 8]);
            da = gf256_mul(syn_w[8*i +: 8] ^ gf256_mul(ALPHA_POW[idx_b], syn_s[8*i +: 8]),
                           denom_inv);
            rb_da[8*i +: 8] = da;
            rb_db[8*i +: 8] = syn_s[8*i +: 8] ^ da;
        end

        fix_data   = raw_q;
        fix_status = StatUncorr;
        if (n_fail == 4'd0) begin
            fix_status = StatClean;
        end else if (n_fail == 4'd1 && !parity_err_q[0]) begin
            fix_data[{idx_a, 7'd0} +: CHIP_W] = syn_s;
            fix_status = StatOne;
        end else if (n_fail == 4'd1 && !parity_err_q[1]) begin
            fix_data[{idx_a, 7'd0} +: CHIP_W] = rb_w1;
            fix_status = StatOne;
        end else if (n_fail == 4'd2 && parity_err_q == 2'b00) begin
            fix_data[{idx_a, 7'd0} +: CHIP_W] = rb_da;
            fix_data[{idx_b, 7'd0} +: CHIP_W] = rb_db;
            fix_status = StatTwo;
        end
    end

`ifdef XED_DEC_RECHECK_EN
    logic [7:0] rc_a, rc_b;
    logic       recheck_bad;

    xed_crc_step u_crc_a (
        .data_i (dout_q[{idx_a, 7'd0} +: CHIP_W]),
        .crc_o  (rc_a)
    );

    xed_crc_step u_crc_b (
        .data_i (dout_q[{idx_b, 7'd0} +: CHIP_W]),
        .crc_o  (rc_b)
    );

    // err_mask is frozen after CHECK, so idx_a/idx_b still name the rebuilt chips
    always_comb begin
        recheck_bad = 1'b0;
        if (status_q == StatOne) begin
            recheck_bad = (rc_a != crc_q[{idx_a, 3'd0} +: 8]);
        end else if (status_q == StatTwo) begin
            recheck_bad = (rc_a != crc_q[{idx_a, 3'd0} +: 8])
                       || (rc_b != crc_q[{idx_b, 3'd0} +: 8]);
        end
    end
`endif

    // Next-state and result registers
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_mask_d   = err_mask_q;
        parity_err_d = parity_err_q;
        dout_d       = dout_q;
        status_d     = status_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d      = StCheck;
                    cnt_d        = 4'd0;
                    err_mask_d   = 8'h00;
                    parity_err_d = 2'b00;
                    dout_d       = '0;
                    status_d     = StatClean;
                end
            end
            StCheck: begin
                if (cnt_q < 4'd8) begin
                    err_mask_d[cnt_q[2:0]] = crc_bad;
                end else if (cnt_q == 4'd8) begin
                    parity_err_d[0] = crc_bad;
                end else begin
                    parity_err_d[1] = crc_bad;
                end
                if (cnt_q == 4'd9) begin
                    cnt_d   = 4'd0;
                    state_d = StCorrect;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StCorrect: begin
                dout_d   = fix_data;
                status_d = fix_status;
`ifdef XED_DEC_RECHECK_EN
                state_d  = StRecheck;
`else
                state_d  = StDone;
`endif
            end
`ifdef XED_DEC_RECHECK_EN
            StRecheck: begin
                if (recheck_bad) begin
                    status_d = StatUncorr;
                    dout_d   = raw_q;
                end
                state_d = StDone;
            end
`endif
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and result state; in_ready tracks the IDLE state one edge behind reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            err_mask_q   <= 8'h00;
            parity_err_q <= 2'b00;
            dout_q       <= '0;
            status_q     <= 2'b00;
            in_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            err_mask_q   <= err_mask_d;
            parity_err_q <= parity_err_d;
            dout_q       <= dout_d;
            status_q     <= status_d;
            in_ready_q   <= (state_d == StIdle);
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = (state_q == StDone);
    assign bus.chip_data_out = dout_q;
    assign bus.err_mask      = err_mask_q;
    assign bus.parity_err    = parity_err_q;
    assign bus.dec_status    = status_q;

endmodule

// File: tb/tb_xed_decoder_10.sv
// Randomised self-checking bench for xed_decoder_10 with a log/antilog GF model and golden data.
module tb_xed_decoder_10;

`ifdef XED_DEC_RECHECK_EN
    localparam int LAT = 13;
`else
    localparam int LAT = 12;
`endif

    typedef struct packed {
        logic [1023:0] data;
        logic [63:0]   crc;
        logic [127:0]  xp;
        logic [127:0]  wp;
        logic [7:0]    sc;
        logic [7:0]    wc;
    } cw_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   gexp [0:511];
    int   glog [0:255];

    xed_decoder_10_if bus ();

    xed_decoder_10 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Bit-serial CRC-8 (poly 0x07, seed FF, inverted), message MSB first
    function automatic logic [7:0] ref_crc(input logic [127:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'hFF;
        for (int i = 127; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return ~c;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return 8'(gexp[(glog[a] + glog[b]) % 255]);
    endfunction

    function automatic cw_t encode(input logic [1023:0] d);
        cw_t cw;
        cw.data = d;
        cw.xp   = '0;
        cw.wp   = '0;
        for (int k = 0; k < 8; k++) begin
            cw.crc[8*k +: 8] = ref_crc(d[128*k +: 128]);
            for (int i = 0; i < 16; i++) begin
                cw.xp[8*i +: 8] = cw.xp[8*i +: 8] ^ d[128*k + 8*i +: 8];
                cw.wp[8*i +: 8] = cw.wp[8*i +: 8] ^ gmul(8'(gexp[k]), d[128*k + 8*i +: 8]);
            end
        end
        cw.sc = ref_crc(cw.xp);
        cw.wc = ref_crc(cw.wp);
        return cw;
    endfunction

    task automatic drive_garbage();
        for (int w = 0; w < 32; w++) bus.chip_data_in[32*w +: 32] = $urandom;
        bus.chip_crc_in     = {$urandom, $urandom};
        bus.xor_parity_in   = {$urandom, $urandom, $urandom, $urandom};
        bus.wxor_parity_in  = {$urandom, $urandom, $urandom, $urandom};
        bus.simple_crc_in   = 8'($urandom);
        bus.weighted_crc_in = 8'($urandom);
    endtask

    task automatic drive_cw(input cw_t rx);
        bus.chip_data_in    = rx.data;
        bus.chip_crc_in     = rx.crc;
        bus.xor_parity_in   = rx.xp;
        bus.wxor_parity_in  = rx.wp;
        bus.simple_crc_in   = rx.sc;
        bus.weighted_crc_in = rx.wc;
    endtask

    // Present rx, wait for the result and compare it with the restoration rules
    task automatic run_cw(input string tag, input cw_t rx, input logic [1023:0] golden,
                          input int hold);
        logic [7:0]    em;
        logic [1:0]    pe;
        logic [1:0]    st;
        logic [1023:0] dexp;
        int            f;
        int            n;
        int            lat;
        for (int k = 0; k < 8; k++) em[k] = (ref_crc(rx.data[128*k +: 128]) != rx.crc[8*k +: 8]);
        pe = {ref_crc(rx.wp) != rx.wc, ref_crc(rx.xp) != rx.sc};
        f  = $countones(em);
        if (f == 0) st = 2'b00;
        else if (f == 1 && pe != 2'b11) st = 2'b01;
        else if (f == 2 && pe == 2'b00) st = 2'b10;
        else st = 2'b11;
        dexp = (st == 2'b01 || st == 2'b10) ? golden : rx.data;

        bus.out_ready = (hold == 0);
        @(negedge clk);
        drive_cw(rx);
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, ":accept"}, 128'(bus.in_ready), 128'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        drive_garbage();
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, ":latency"}, 128'(lat), 128'(LAT));
        check_eq({tag, ":err_mask"}, 128'(bus.err_mask), 128'(em));
        check_eq({tag, ":parity_err"}, 128'(bus.parity_err), 128'(pe));
        check_eq({tag, ":status"}, 128'(bus.dec_status), 128'(st));
        check_eq({tag, ":in_ready_busy"}, 128'(bus.in_ready), 128'd0);
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("%s:chip%0d", tag, k), bus.chip_data_out[128*k +: 128],
                     dexp[128*k +: 128]);
        end
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                check_eq({tag, ":hold_valid"}, 128'(bus.out_valid), 128'd1);
                check_eq({tag, ":hold_ready"}, 128'(bus.in_ready), 128'd0);
                check_eq({tag, ":hold_status"}, 128'(bus.dec_status), 128'(st));
                check_eq({tag, ":hold_chip"}, bus.chip_data_out[0 +: 128], dexp[0 +: 128]);
            end
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        check_eq({tag, ":valid_drop"}, 128'(bus.out_valid), 128'd0);
        check_eq({tag, ":ready_back"}, 128'(bus.in_ready), 128'd1);
    endtask

    initial begin
        logic [1023:0] base;
        logic [1023:0] rnd;
        cw_t           gold;
        cw_t           rx;
        logic [7:0]    pm;
        int            nc;
        int            seen;
        int            v;

        n_checks = 0;
        n_errors = 0;
        v = 1;
        for (int i = 0; i < 512; i++) begin
            gexp[i] = v;
            if (i < 255) glog[v] = i;
            v = v << 1;
            if (v & 256) v = v ^ 'h11D;
        end
        glog[0] = 0;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive_garbage();
        repeat (2) @(negedge clk);
        check_eq("reset:in_ready", 128'(bus.in_ready), 128'd0);
        check_eq("reset:out_valid", 128'(bus.out_valid), 128'd0);
        check_eq("reset:status", 128'(bus.dec_status), 128'd0);
        check_eq("reset:err_mask", 128'(bus.err_mask), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("reset:in_ready_rise", 128'(bus.in_ready), 128'd1);

        for (int k = 0; k < 8; k++) base[128*k +: 128] = {16{8'(8'h11 * k)}};
        gold = encode(base);

        run_cw("clean", gold, base, 0);

        rx = gold;
        rx.data[3*128 +: 8] = rx.data[3*128 +: 8] ^ 8'hA5;
        run_cw("chip3", rx, base, 0);

        rx = gold;
        rx.data[1*128 +: 128] = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
        rx.data[6*128 +: 128] = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
        run_cw("chips16", rx, base, 0);

        rx = gold;
        rx.data[5*128 + 8*7 +: 8] = rx.data[5*128 + 8*7 +: 8] ^ 8'h3C;
        rx.sc = rx.sc ^ 8'h01;
        run_cw("chip5_wt", rx, base, 0);

        rx = gold;
        rx.data[0*128 +: 8]       = rx.data[0*128 +: 8] ^ 8'h01;
        rx.data[2*128 + 40 +: 8]  = rx.data[2*128 + 40 +: 8] ^ 8'h80;
        rx.data[7*128 + 120 +: 8] = rx.data[7*128 + 120 +: 8] ^ 8'h5A;
        run_cw("chips027", rx, base, 0);

        rx = gold;
        rx.data[4*128 + 16 +: 8] = rx.data[4*128 + 16 +: 8] ^ 8'hFF;
        run_cw("backpressure", rx, base, 5);

        // Reset during CHECK drops the codeword
        @(negedge clk);
        drive_cw(gold);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst:out_valid", 128'(bus.out_valid), 128'd0);
        check_eq("midrst:err_mask", 128'(bus.err_mask), 128'd0);
        check_eq("midrst:status", 128'(bus.dec_status), 128'd0);
        check_eq("midrst:in_ready", 128'(bus.in_ready), 128'd0);
        check_eq("midrst:chip0", bus.chip_data_out[0 +: 128], 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (16) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check_eq("midrst:no_valid", 128'(seen), 128'd0);
        run_cw("after_rst", gold, base, 0);

        for (int t = 0; t < 24; t++) begin
            for (int w = 0; w < 32; w++) rnd[32*w +: 32] = $urandom;
            gold = encode(rnd);
            rx = gold;
            nc = $urandom_range(0, 3);
            pm = 8'h00;
            while ($countones(pm) < nc) pm[$urandom_range(0, 7)] = 1'b1;
            for (int k = 0; k < 8; k++) begin
                if (pm[k]) begin
                    v = $urandom_range(0, 15);
                    rx.data[128*k + 8*v +: 8] = rx.data[128*k + 8*v +: 8]
                                              ^ 8'($urandom_range(1, 255));
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) rx.sc = rx.sc ^ 8'($urandom_range(1, 255));
                else rx.xp[8*$urandom_range(0, 15) +: 8] = rx.xp[8*$urandom_range(0, 15) +: 8] ^ 8'h00 ^ 8'hFF;
            end
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) rx.wc = rx.wc ^ 8'($urandom_range(1, 255));
                else rx.wp[8*3 +: 8] = rx.wp[8*3 +: 8] ^ 8'($urandom_range(1, 255));
            end
            run_cw($sformatf("rand%0d", t), rx, rnd,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
